mem_responder: RTL and testbench

//   Word-addressed memory target for the MiniSRC datapath. It answers the Read/Write

---
 rtl/mem_responder.sv | 112 +++++++++++
 tb/tb_mem_responder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed memory target with wait states and a Ready/Busy/Err handshake.
// Ports: Clock, Clear(n), Read, Write, Address, DataIn -> DataOut, Ready, Busy, Err.
module mem_responder #(
  parameter int    ADDR_W      = 9,
  parameter int    DATA_W      = 32,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              Read,
  input  logic              Write,
  input  logic [31:0]       Address,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              Ready,
  output logic              Busy,
  output logic              Err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RELEASE
  } state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  state_t            state;
  state_t            nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              wr_q;
  logic              accept;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_wr;
  logic              unused_addr;

  assign unused_addr = ^Address[31:ADDR_W];
  assign accept      = (state == S_IDLE) && (Read || Write);

  // With zero wait states ACCESS follows acceptance directly,
  // so the read data must come from the live inputs.
  assign acc_addr = (state == S_IDLE) ? Address[ADDR_W-1:0]
                                      : addr_q;
  assign acc_wr   = (state == S_IDLE) ? Write : wr_q;

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    unique case (state)
      S_IDLE: begin
        if (Read || Write) begin
          if (WS != 4'd0) begin
            nxt     = S_WAIT;
            cnt_nxt = WS - 4'd1;
          end else begin
            nxt = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) nxt = S_ACCESS;
        else cnt_nxt = cnt - 4'd1;
      end
      S_ACCESS: nxt = S_RELEASE;
      S_RELEASE: begin
        if (!Read && !Write) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      DataOut <= '0;
      Ready   <= 1'b0;
      Busy    <= 1'b0;
      Err     <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      Ready <= (nxt == S_ACCESS);
      Busy  <= (nxt == S_WAIT) || (nxt == S_ACCESS);
      Err   <= accept && Read && Write;
      if (accept) begin
        addr_q <= Address[ADDR_W-1:0];
        data_q <= DataIn;
        wr_q   <= Write;
      end
      if (nxt == S_ACCESS && !acc_wr)
        DataOut <= mem[acc_addr];
    end
  end

  // Array has no reset; a reset before ACCESS drops the write.
  always_ff @(posedge Clock) begin
    if (state == S_ACCESS && wr_q)
      mem[addr_q] <= data_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (1 and 0 wait states).
// Drives after posedge, samples 1 time unit later.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd, wr;
  logic [31:0] addr, din;
  logic [31:0] dout;
  logic        rdy, bsy, err;

  logic        rd0, wr0;
  logic [31:0] addr0, din0;
  logic [31:0] dout0;
  logic        rdy0, bsy0, err0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_responder #(.WAIT_STATES(1)) u_dut (
    .Clock(clk), .Clear(rst_n),
    .Read(rd), .Write(wr),
    .Address(addr), .DataIn(din),
    .DataOut(dout), .Ready(rdy),
    .Busy(bsy), .Err(err)
  );

  mem_responder #(.WAIT_STATES(0)) u_dut0 (
    .Clock(clk), .Clear(rst_n),
    .Read(rd0), .Write(wr0),
    .Address(addr0), .DataIn(din0),
    .DataOut(dout0), .Ready(rdy0),
    .Busy(bsy0), .Err(err0)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One transaction on the 1-wait-state instance.
  task automatic op(input logic r, input logic w,
                    input logic [31:0] a,
                    input logic [31:0] d,
                    input logic exp_err);
    int lat;
    rd = r; wr = w; addr = a; din = d;
    tick;
    chk("busy_acc", {31'd0, bsy}, 32'd1);
    chk("err_acc", {31'd0, err}, {31'd0, exp_err});
    lat = 1;
    while (!rdy && lat < 20) begin
      tick;
      lat++;
    end
    chk("latency", lat, 32'd2);
    chk("err_rdy", {31'd0, err}, 32'd0);
    addr = 32'hFFFF_FFFF; din = 32'h0;
    tick;
    chk("rdy_drop", {31'd0, rdy}, 32'd0);
    chk("busy_rel", {31'd0, bsy}, 32'd0);
    rd = 0; wr = 0;
    tick;
  endtask

  initial begin
    int pulses;
    rst_n = 0;
    rd = 0; wr = 0; addr = 0; din = 0;
    rd0 = 0; wr0 = 0; addr0 = 0; din0 = 0;
    tick;
    chk("rst_dout", dout, 32'h0);
    chk("rst_rdy", {31'd0, rdy}, 32'd0);
    chk("rst_busy", {31'd0, bsy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1;
    tick;

    op(0, 1, 32'h12, 32'hDEADBEEF, 0);
    op(1, 0, 32'h12, 32'h0, 0);
    chk("rd_12", dout, 32'hDEADBEEF);

    op(1, 0, 32'h212, 32'h0, 0);
    chk("alias_212", dout, 32'hDEADBEEF);
    op(0, 1, 32'h200, 32'h0BADF00D, 0);
    chk("wr_hold", dout, 32'hDEADBEEF);
    op(1, 0, 32'h000, 32'h0, 0);
    chk("alias_000", dout, 32'h0BADF00D);

    op(1, 1, 32'h05, 32'h000000A5, 1);
    chk("both_hold", dout, 32'h0BADF00D);
    op(1, 0, 32'h05, 32'h0, 0);
    chk("rd_05", dout, 32'hA5);

    op(0, 1, 32'h30, 32'h11111111, 0);
    op(1, 0, 32'h30, 32'h0, 0);
    chk("rd_30", dout, 32'h11111111);
    rd = 0; wr = 1; addr = 32'h30; din = 32'h22222222;
    tick;
    chk("wait_busy", {31'd0, bsy}, 32'd1);
    #1 rst_n = 0;
    #1;
    chk("async_dout", dout, 32'h0);
    chk("async_rdy", {31'd0, rdy}, 32'd0);
    chk("async_busy", {31'd0, bsy}, 32'd0);
    wr = 0;
    tick;
    rst_n = 1;
    tick;
    op(1, 0, 32'h30, 32'h0, 0);
    chk("abort_30", dout, 32'h11111111);

    wr0 = 1; addr0 = 32'h7; din0 = 32'hCAFE0007;
    tick;
    chk("ws0_rdy", {31'd0, rdy0}, 32'd1);
    wr0 = 0;
    tick;
    tick;
    rd0 = 1; addr0 = 32'h7;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (rdy0) pulses++;
      if (i == 0) begin
        chk("ws0_rd_rdy", {31'd0, rdy0}, 32'd1);
        chk("ws0_busy1", {31'd0, bsy0}, 32'd1);
      end
      if (i == 1)
        chk("ws0_busy2", {31'd0, bsy0}, 32'd0);
    end
    chk("ws0_pulses", pulses, 32'd1);
    chk("ws0_dout", dout0, 32'hCAFE0007);
    rd0 = 0;
    tick;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
